// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude compare controller.
package cmp_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Requester-side handshake and result bus of the serial comparator.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             smaller;
  logic             greater;
  logic             equal;
  logic [CNT_W-1:0] bits_used;

  modport master (
    output start, a_in, b_in,
    input  busy, done, smaller, greater, equal, bits_used
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, smaller, greater, equal, bits_used
  );
endinterface

// File: rtl/serial_cmp_ctrl_cmp.sv
// Combinational 1-bit magnitude comparator cell.
module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic smaller,
  output logic greater,
  output logic equal
);
  assign smaller = ~a & b;
  assign greater = a & ~b;
  assign equal   = ~(a ^ b);
endmodule

// File: rtl/serial_cmp_ctrl.sv
// MSB-first bit-serial compare of two unsigned words on a shared 1-bit cell,
// terminating on the first differing bit.
module serial_cmp_ctrl
  import cmp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  serial_cmp_ctrl_if.slave bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             smaller, greater, equal;
  logic [CNT_W-1:0] bits_used;
  logic             c_sm, c_gt, c_eq;

  comparator_1bit u_cell (
    .a       (sa[WIDTH-1]),
    .b       (sb[WIDTH-1]),
    .smaller (c_sm),
    .greater (c_gt),
    .equal   (c_eq)
  );

  wire last_bit = (idx == '0);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.start)          state_n = ST_CMP;
      ST_CMP:  if (!c_eq || last_bit)  state_n = ST_DONE;
      ST_DONE:                         state_n = ST_IDLE;
      default:                         state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sa        <= '0;
      sb        <= '0;
      idx       <= '0;
      cnt       <= '0;
      smaller   <= 1'b0;
      greater   <= 1'b0;
      equal     <= 1'b0;
      bits_used <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: if (bus.start) begin
          sa  <= bus.a_in;
          sb  <= bus.b_in;
          idx <= IDX_W'(WIDTH - 1);
          cnt <= '0;
        end
        ST_CMP: begin
          cnt <= cnt + CNT_W'(1);
          // Results only move at the terminating bit so they stay stable mid-compare.
          if (!c_eq) begin
            smaller   <= c_sm;
            greater   <= c_gt;
            equal     <= 1'b0;
            bits_used <= cnt + CNT_W'(1);
          end else if (last_bit) begin
            smaller   <= 1'b0;
            greater   <= 1'b0;
            equal     <= 1'b1;
            bits_used <= CNT_W'(WIDTH);
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            idx <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == ST_CMP) || (state == ST_DONE);
  assign bus.done      = (state == ST_DONE);
  assign bus.smaller   = smaller;
  assign bus.greater   = greater;
  assign bus.equal     = equal;
  assign bus.bits_used = bits_used;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl at WIDTH=8 with hand-computed expectations.
`timescale 1ns/1ps
module tb_serial_cmp_ctrl;
  import cmp_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #500 clk = ~clk;

  serial_cmp_ctrl_if #(.WIDTH(8)) bus ();
  serial_cmp_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int k, input logic sm, input logic gt, input logic eq);
    int n;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(k));
    chk({tag, "_state"}, 32'(dut.state), 32'(ST_DONE));
    chk({tag, "_sm"}, 32'(bus.smaller), 32'(sm));
    chk({tag, "_gt"}, 32'(bus.greater), 32'(gt));
    chk({tag, "_eq"}, 32'(bus.equal), 32'(eq));
    chk({tag, "_bits"}, 32'(bus.bits_used), 32'(k));
    tick();
    chk({tag, "_done_off"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int first;
    int last;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res", {29'd0, bus.smaller, bus.greater, bus.equal}, 32'd0);
    chk("rst_bits", 32'(bus.bits_used), 32'd0);
    tick();

    // Directed compares
    run_cmp("msb_diff", 8'h80, 8'h7F, 1, 1'b0, 1'b1, 1'b0);
    run_cmp("lsb_diff", 8'h12, 8'h13, 8, 1'b1, 1'b0, 1'b0);
    run_cmp("equal",    8'hA5, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
    run_cmp("mid_diff", 8'h2C, 8'h24, 5, 1'b0, 1'b1, 1'b0);

    // Start while busy is ignored, as are operand changes after capture
    bus.a_in = 8'h12; bus.b_in = 8'h13; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.a_in = 8'h00; bus.b_in = 8'hFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) begin
        pulses++;
        chk("busy_ign_sm", 32'(bus.smaller), 32'd1);
        chk("busy_ign_bits", 32'(bus.bits_used), 32'd8);
      end
    end
    chk("busy_ign_pulses", 32'(pulses), 32'd1);

    // Reset during the 3rd CMP cycle of an equal compare
    bus.a_in = 8'h5A; bus.b_in = 8'h5A; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_res", {29'd0, bus.smaller, bus.greater, bus.equal}, 32'd0);
    chk("midrst_bits", 32'(bus.bits_used), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);

    // Start held high: back-to-back k=2 compares every 4 cycles
    bus.a_in = 8'h40; bus.b_in = 8'h00; bus.start = 1'b1;
    pulses = 0; first = -1; last = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done) begin
        if (first < 0) first = i;
        else chk("b2b_period", 32'(i - last), 32'd4);
        last = i;
        pulses++;
        chk("b2b_gt", 32'(bus.greater), 32'd1);
        chk("b2b_bits", 32'(bus.bits_used), 32'd2);
      end
    end
    bus.start = 1'b0;
    chk("b2b_first", 32'(first), 32'd3);
    chk("b2b_pulses", 32'(pulses), 32'd5);
    tick();
    tick();
    chk("b2b_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
